// File: rtl/rf_wb_ctrl.sv
// Register-file write-back controller: queues ALU and memory results, drains one
// write per cycle to the file's write port, and serves a two-port bypass lookup.
module rf_wb_ctrl #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   alu_valid,
   input  logic [4:0]             alu_rd,
   input  logic [XLEN-1:0]        alu_data,
   output logic                   alu_ready,
   input  logic                   mem_valid,
   input  logic [4:0]             mem_rd,
   input  logic [XLEN-1:0]        mem_data,
   output logic                   mem_ready,
   output logic                   rf_write_e,
   output logic [4:0]             rf_rd,
   output logic [XLEN-1:0]        rf_write_d,
   input  logic [4:0]             fwd_s1,
   input  logic [4:0]             fwd_s2,
   output logic                   fwd_hit1,
   output logic [XLEN-1:0]        fwd_d1,
   output logic                   fwd_hit2,
   output logic [XLEN-1:0]        fwd_d2,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [4:0]      r_rd   [DEPTH];
   logic [XLEN-1:0] r_data [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [PW-1:0]   r_rptr;
   logic [PW-1:0]   r_wptr;
   logic [CW-1:0]   r_count;

   logic [CW-1:0]   w_free;
   logic            w_empty;
   logic            w_pop;
   logic            w_mem_push;
   logic            w_alu_push;
   logic [PW-1:0]   w_alu_slot;

   // Credit comes only from registered occupancy; a same-cycle pop earns nothing.
   assign w_free     = CW'(DEPTH) - r_count;
   assign w_empty    = (r_count == '0);
   assign w_pop      = !w_empty;
   assign mem_ready  = (w_free >= CW'(1));
   assign alu_ready  = (w_free >= CW'(2)) || ((w_free >= CW'(1)) && !mem_valid);

   // x0 results complete the handshake but never occupy a slot.
   assign w_mem_push = mem_valid && mem_ready && (mem_rd != 5'd0);
   assign w_alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
   assign w_alu_slot = r_wptr + PW'(w_mem_push);

   assign rf_write_e = !w_empty;
   assign rf_rd      = w_empty ? 5'd0 : r_rd[r_rptr];
   assign rf_write_d = w_empty ? '0   : r_data[r_rptr];
   assign count      = r_count;

   // Entry payload is not reset; validity is tracked separately.
   always_ff @(posedge clk) begin
      if (w_mem_push) begin
         r_rd[r_wptr]   <= mem_rd;
         r_data[r_wptr] <= mem_data;
      end
      if (w_alu_push) begin
         r_rd[w_alu_slot]   <= alu_rd;
         r_data[w_alu_slot] <= alu_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
         r_vld   <= '0;
      end else begin
         if (w_pop) begin
            r_vld[r_rptr] <= 1'b0;
            r_rptr        <= r_rptr + PW'(1);
         end
         if (w_mem_push) r_vld[r_wptr]     <= 1'b1;
         if (w_alu_push) r_vld[w_alu_slot] <= 1'b1;
         r_wptr  <= r_wptr + PW'(w_mem_push) + PW'(w_alu_push);
         r_count <= r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
      end
   end

   // Walk oldest to youngest so the last match left standing is the youngest.
   always_comb begin
      fwd_hit1 = 1'b0;
      fwd_d1   = '0;
      fwd_hit2 = 1'b0;
      fwd_d2   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [PW-1:0] idx;
         idx = r_rptr + PW'(i);
         if (r_vld[idx] && (fwd_s1 != 5'd0) && (r_rd[idx] == fwd_s1)) begin
            fwd_hit1 = 1'b1;
            fwd_d1   = r_data[idx];
         end
         if (r_vld[idx] && (fwd_s2 != 5'd0) && (r_rd[idx] == fwd_s2)) begin
            fwd_hit2 = 1'b1;
            fwd_d2   = r_data[idx];
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_rf_wb_ctrl;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned XLEN  = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            alu_valid, mem_valid;
   logic [4:0]      alu_rd, mem_rd, fwd_s1, fwd_s2;
   logic [XLEN-1:0] alu_data, mem_data;
   logic            alu_ready, mem_ready, rf_write_e, fwd_hit1, fwd_hit2;
   logic [4:0]      rf_rd;
   logic [XLEN-1:0] rf_write_d, fwd_d1, fwd_d2;
   logic [2:0]      count;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] d;
   } ent_t;
   ent_t q[$];

   always #5 clk = ~clk;

   rf_wb_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .rf_write_e(rf_write_e), .rf_rd(rf_rd), .rf_write_d(rf_write_d),
      .fwd_s1(fwd_s1), .fwd_s2(fwd_s2),
      .fwd_hit1(fwd_hit1), .fwd_d1(fwd_d1), .fwd_hit2(fwd_hit2), .fwd_d2(fwd_d2),
      .count(count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_free();
      return int'(DEPTH) - q.size();
   endfunction

   function automatic logic m_mem_ready();
      return m_free() >= 1;
   endfunction

   function automatic logic m_alu_ready();
      return (m_free() >= 2) || (m_free() >= 1 && !mem_valid);
   endfunction

   // Youngest pending entry targeting s, or a miss; x0 never hits.
   task automatic m_lookup(input logic [4:0] s, output logic hit, output logic [XLEN-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (s != 5'd0) begin
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].rd == s) begin
               hit = 1'b1;
               d   = q[i].d;
               break;
            end
         end
      end
   endtask

   task automatic model_check();
      logic h1, h2;
      logic [XLEN-1:0] d1, d2;
      m_lookup(fwd_s1, h1, d1);
      m_lookup(fwd_s2, h2, d2);
      chk("mem_ready", 32'(mem_ready), 32'(m_mem_ready()));
      chk("alu_ready", 32'(alu_ready), 32'(m_alu_ready()));
      chk("count", 32'(count), 32'(q.size()));
      chk("rf_write_e", 32'(rf_write_e), 32'(q.size() != 0));
      chk("rf_rd", 32'(rf_rd), (q.size() != 0) ? 32'(q[0].rd) : 32'd0);
      chk("rf_write_d", rf_write_d, (q.size() != 0) ? q[0].d : 32'd0);
      chk("fwd_hit1", 32'(fwd_hit1), 32'(h1));
      chk("fwd_d1", fwd_d1, d1);
      chk("fwd_hit2", 32'(fwd_hit2), 32'(h2));
      chk("fwd_d2", fwd_d2, d2);
   endtask

   // Drive one cycle's inputs away from the active edge and compare to the model.
   task automatic cyc_begin(input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] md,
                            input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                            input logic [4:0] s1, input logic [4:0] s2);
      @(negedge clk);
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      fwd_s1 = s1; fwd_s2 = s2;
      #1;
      model_check();
   endtask

   // Advance through the edge and apply the same handshakes to the model.
   task automatic cyc_end();
      logic acc_m, acc_a;
      acc_m = mem_valid && m_mem_ready() && (mem_rd != 5'd0);
      acc_a = alu_valid && m_alu_ready() && (alu_rd != 5'd0);
      @(posedge clk);
      if (q.size() != 0) void'(q.pop_front());
      if (acc_m) q.push_back('{rd: mem_rd, d: mem_data});
      if (acc_a) q.push_back('{rd: alu_rd, d: alu_data});
   endtask

   task automatic idle(input logic [4:0] s1);
      cyc_begin(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, s1, 5'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      fwd_s1 = '0; fwd_s2 = '0;
      #12;
      chk("reset_rf_write_e", 32'(rf_write_e), 32'd0);
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_rf_write_d", rf_write_d, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single ALU write.
      cyc_begin(1'b0, 5'd0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
      chk("t1_alu_ready", 32'(alu_ready), 32'd1);
      cyc_end();
      idle(5'd0);
      chk("t1_we", 32'(rf_write_e), 32'd1);
      chk("t1_rd", 32'(rf_rd), 32'd5);
      chk("t1_data", rf_write_d, 32'hDEADBEEF);
      chk("t1_count", 32'(count), 32'd1);
      cyc_end();
      idle(5'd0);
      chk("t1_we_after", 32'(rf_write_e), 32'd0);
      chk("t1_count_after", 32'(count), 32'd0);
      cyc_end();

      // Simultaneous sources to the same rd.
      cyc_begin(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd0, 5'd0);
      chk("t2_mem_ready", 32'(mem_ready), 32'd1);
      chk("t2_alu_ready", 32'(alu_ready), 32'd1);
      cyc_end();
      idle(5'd3);
      chk("t2_first", rf_write_d, 32'h11);
      chk("t2_hit", 32'(fwd_hit1), 32'd1);
      chk("t2_fwd_young", fwd_d1, 32'h22);
      cyc_end();
      idle(5'd3);
      chk("t2_second", rf_write_d, 32'h22);
      chk("t2_fwd_head", fwd_d1, 32'h22);
      cyc_end();

      // x0 suppression.
      cyc_begin(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
      chk("t3_alu_ready", 32'(alu_ready), 32'd1);
      cyc_end();
      idle(5'd0);
      chk("t3_count", 32'(count), 32'd0);
      chk("t3_we", 32'(rf_write_e), 32'd0);
      chk("t3_hit", 32'(fwd_hit1), 32'd0);
      cyc_end();

      // Fill under constant pressure: occupancy saturates at DEPTH-1 with 1 pop/cycle.
      cyc_begin(1'b1, 5'd8, 32'h801, 1'b1, 5'd9, 32'h901, 5'd8, 5'd9);
      cyc_end();
      cyc_begin(1'b1, 5'd8, 32'h802, 1'b1, 5'd9, 32'h902, 5'd8, 5'd9);
      chk("t4_count2", 32'(count), 32'd2);
      chk("t4_alu_ready2", 32'(alu_ready), 32'd1);
      cyc_end();
      cyc_begin(1'b1, 5'd8, 32'h803, 1'b1, 5'd9, 32'h903, 5'd8, 5'd9);
      chk("t4_count3", 32'(count), 32'd3);
      chk("t4_alu_blocked", 32'(alu_ready), 32'd0);
      chk("t4_mem_ok", 32'(mem_ready), 32'd1);
      cyc_end();
      cyc_begin(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h904, 5'd8, 5'd9);
      chk("t4_count3b", 32'(count), 32'd3);
      chk("t4_alu_ok", 32'(alu_ready), 32'd1);
      cyc_end();
      repeat (4) begin idle(5'd9); cyc_end(); end

      // Wrap-around stream.
      for (int r = 1; r <= 10; r++) begin
         cyc_begin(1'b0, 5'd0, '0, 1'b1, 5'(r), 32'(r * 32'h100), 5'd0, 5'd0);
         if (r > 1) begin
            chk("t5_rd", 32'(rf_rd), 32'(r - 1));
            chk("t5_count", 32'(count), 32'd1);
         end
         cyc_end();
      end
      idle(5'd0);
      chk("t5_last", rf_write_d, 32'hA00);
      cyc_end();

      // Async reset with entries queued.
      cyc_begin(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 5'd0, 5'd0);
      cyc_end();
      cyc_begin(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4, 5'd0, 5'd0);
      cyc_end();
      idle(5'd3);
      chk("t6_count_pre", 32'(count), 32'd3);
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("t6_we", 32'(rf_write_e), 32'd0);
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_hit1", 32'(fwd_hit1), 32'd0);
      chk("t6_hit2", 32'(fwd_hit2), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc_begin(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h77, 5'd0, 5'd0);
      cyc_end();
      idle(5'd7);
      chk("t6_new_rd", 32'(rf_rd), 32'd7);
      chk("t6_new_data", rf_write_d, 32'h77);
      chk("t6_new_count", 32'(count), 32'd1);
      cyc_end();
      idle(5'd0);
      chk("t6_alone", 32'(rf_write_e), 32'd0);
      cyc_end();

      // Randomized traffic; small rd range makes bypass hits and WAW frequent.
      for (int n = 0; n < 400; n++) begin
         cyc_begin(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         cyc_end();
      end
      repeat (5) begin idle(5'd0); cyc_end(); end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
